mem_arbiter: RTL

Two-port round-robin arbiter and sequencer in front of the single-port `MEMORY` block (5-bit address, 32-bit word). Two requesters (port 0, e.g. fetch; port 1, e.g. load/store) issue read or write requests with a req/ack handshake. The arbiter grants one at a time, drives the memory's `addr`/`r_en`/`w_en`/`data_in`, captures `data_out` into a register, and returns it with a one-cycle ack pulse. It is the only driver of the shared memory.

---
 rtl/mem_pkg.sv | 16 +
 rtl/MEMORY.sv | 31 +++
 rtl/rr_pick2.sv | 22 ++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_pkg;

  localparam int ADDR_LEN  = 5;
  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/MEMORY.sv
// Single-port word memory: clocked write, combinational read gated by r_en.
module MEMORY #(
  parameter int ADDR_LEN  = 5,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic [ADDR_LEN-1:0]  addr,
  input  logic                 r_en,
  input  logic                 w_en,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out
);

  logic [WORD_SIZE-1:0] r_mem [2**ADDR_LEN];

  // Store the presented word whenever the write enable is high at the edge.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_mem[addr] <= data_in;
    end
  end

  // Read port returns zero while not enabled.
  always_comb begin
    data_out = '0;
    if (r_en) begin
      data_out = r_mem[addr];
    end
  end

endmodule

// File: rtl/rr_pick2.sv
// Two-requester round-robin winner select (purely combinational).
module rr_pick2 (
  input  logic p0_req,
  input  logic p1_req,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_id
);
  import mem_pkg::*;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    gnt_valid = p0_req | p1_req;
    gnt_id    = PORT0;
    if (p0_req && p1_req) begin
      gnt_id = ~last_gnt;
    end else if (p1_req) begin
      gnt_id = PORT1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer in front of a single-port MEMORY.
module mem_arbiter #(
  parameter int ADDR_LEN  = mem_pkg::ADDR_LEN,
  parameter int WORD_SIZE = mem_pkg::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_req,
  input  logic                 p1_req,
  input  logic                 p0_we,
  input  logic                 p1_we,
  input  logic [ADDR_LEN-1:0]  p0_addr,
  input  logic [ADDR_LEN-1:0]  p1_addr,
  input  logic [WORD_SIZE-1:0] p0_wdata,
  input  logic [WORD_SIZE-1:0] p1_wdata,
  output logic                 p0_ack,
  output logic                 p1_ack,
  output logic [WORD_SIZE-1:0] p0_rdata,
  output logic [WORD_SIZE-1:0] p1_rdata,
  output logic                 busy,
  output logic [ADDR_LEN-1:0]  mem_addr,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic [WORD_SIZE-1:0] mem_data_in,
  input  logic [WORD_SIZE-1:0] mem_data_out
);
  import mem_pkg::*;

  state_t               r_state;
  state_t               w_next;
  logic                 r_last_gnt;
  logic                 r_gnt_id;
  logic                 r_we;
  logic [ADDR_LEN-1:0]  r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_rdata;
  logic                 w_gnt_valid;
  logic                 w_gnt_id;
  logic                 w_r_en;
  logic                 w_w_en;

  rr_pick2 u_pick (
    .p0_req    (p0_req),
    .p1_req    (p1_req),
    .last_gnt  (r_last_gnt),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  // State register plus request latches, read capture and fairness history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= PORT1;
      r_gnt_id   <= PORT0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_gnt_id <= w_gnt_id;
            r_we     <= (w_gnt_id == PORT1) ? p1_we    : p0_we;
            r_addr   <= (w_gnt_id == PORT1) ? p1_addr  : p0_addr;
            r_wdata  <= (w_gnt_id == PORT1) ? p1_wdata : p0_wdata;
          end
        end
        ST_ACCESS: begin
          if (!r_we) begin
            r_rdata <= mem_data_out;
          end
        end
        ST_DONE: begin
          r_last_gnt <= r_gnt_id;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and per-state outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    p0_ack = 1'b0;
    p1_ack = 1'b0;
    w_r_en = 1'b0;
    w_w_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        busy   = 1'b1;
        w_r_en = ~r_we;
        w_w_en = r_we;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        busy   = 1'b1;
        p0_ack = (r_gnt_id == PORT0);
        p1_ack = (r_gnt_id == PORT1);
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Enables are gated by rst so a reset during ACCESS can never write.
  assign mem_r_en    = w_r_en & ~rst;
  assign mem_w_en    = w_w_en & ~rst;
  assign mem_addr    = r_addr;
  assign mem_data_in = r_wdata;
  assign p0_rdata    = r_rdata;
  assign p1_rdata    = r_rdata;

endmodule
